alu_shift_sequencer: RTL and testbench

Multi-cycle controller that executes a shift or rotate by an arbitrary count by issuing repeated single-bit operations to the combinational `alu` block. It sits between the execution-unit microsequencer and the `alu`, owning the ALU operand and opcode inputs while busy. It latches the operand and count on `start` and iterates one bit per cycle. It then returns the final result and flags with a one-cycle `done` pulse.

---
 rtl/alu_shift_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_shift_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_shift_sequencer
// Purpose  : Runs a multi-bit shift/rotate as repeated 1-bit ALU operations.
// Revision : 1.0
// ============================================================================
module alu_shift_sequencer #(
  parameter logic [4:0] COUNT_MASK = 5'h1F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic        size,
  input  logic [15:0] operand,
  input  logic [7:0]  count,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [5:0]  flags,
  output logic        flags_we,
  output logic [4:0]  alu_op,
  output logic        alu_size,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_r,
  input  logic [5:0]  alu_flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] c_op_rol  = 5'd8;
  localparam logic [4:0] c_op_ror  = 5'd9;
  localparam logic [4:0] c_op_shl  = 5'd12;
  localparam logic [4:0] c_op_shr  = 5'd13;
  localparam logic [4:0] c_op_shra = 5'd15;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [4:0]  r_rem;
  logic [4:0]  r_op;
  logic        r_size;
  logic [7:0]  r_hi;
  logic        r_busy;
  logic        r_done;
  logic        r_flags_we;
  logic [15:0] r_result;
  logic [5:0]  r_flags;

  logic [4:0]  w_rem_init;
  logic        w_op_ok;
  logic        w_unused_count;

  // Only the low five count bits are architecturally meaningful.
  assign w_rem_init     = count[4:0] & COUNT_MASK;
  assign w_unused_count = ^count[7:5];

  // Carry-in rotates and SHLA are excluded: the ALU has no carry input.
  assign w_op_ok = (op == c_op_rol) || (op == c_op_ror) || (op == c_op_shl) ||
                   (op == c_op_shr) || (op == c_op_shra);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_acc      <= 16'd0;
      r_rem      <= 5'd0;
      r_op       <= 5'd0;
      r_size     <= 1'b0;
      r_hi       <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_flags_we <= 1'b0;
      r_result   <= 16'd0;
      r_flags    <= 6'd0;
    end else begin
      r_done     <= 1'b0;
      r_flags_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc  <= operand;
            r_rem  <= w_rem_init;
            r_op   <= op;
            r_size <= size;
            r_hi   <= operand[15:8];
            r_busy <= 1'b1;
            if ((w_rem_init == 5'd0) || !w_op_ok) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= operand;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_acc   <= alu_r;
          r_flags <= alu_flags;
          r_rem   <= r_rem - 5'd1;
          if (r_rem == 5'd1) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_flags_we <= 1'b1;
            // A byte op must leave the upper byte exactly as it arrived.
            r_result   <= r_size ? alu_r : {r_hi, alu_r[7:0]};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    alu_op   = 5'd0;
    alu_size = 1'b0;
    alu_a    = 16'd0;
    alu_b    = 16'd0;
    if (r_state == S_RUN) begin
      alu_op   = r_op;
      alu_size = r_size;
      alu_a    = r_acc;
      alu_b    = 16'd1;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign flags    = r_flags;
  assign flags_we = r_flags_we;

endmodule
`default_nettype wire

// File: tb/tb_alu_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_shift_sequencer
// Purpose  : Scoreboard bench with a 1-bit shift ALU model behind the DUT.
// Revision : 1.0
// ============================================================================
module tb_alu_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  op;
  logic        size;
  logic [15:0] operand;
  logic [7:0]  count;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [5:0]  flags;
  logic        flags_we;
  logic [4:0]  alu_op;
  logic        alu_size;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_r;
  logic [5:0]  alu_flags;

  always #5 clk = ~clk;

  alu_shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .size      (size),
    .operand   (operand),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flags     (flags),
    .flags_we  (flags_we),
    .alu_op    (alu_op),
    .alu_size  (alu_size),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_r     (alu_r),
    .alu_flags (alu_flags)
  );

  // Single-bit ALU model; byte ops deliberately scribble on the upper byte.
  function automatic logic [21:0] alu_model(input logic [4:0] opc, input logic sz,
                                            input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        cy;
    logic        msb;
    logic        z;
    r  = 16'hDEAD;
    cy = 1'b0;
    if (b == 16'd1) begin
      if (!sz) begin
        case (opc)
          5'd8:  begin r = {8'hFF, a[6:0], a[7]};     cy = a[7]; end
          5'd9:  begin r = {8'hFF, a[0], a[7:1]};     cy = a[0]; end
          5'd12: begin r = {8'hFF, a[6:0], 1'b0};     cy = a[7]; end
          5'd13: begin r = {8'hFF, 1'b0, a[7:1]};     cy = a[0]; end
          5'd15: begin r = {8'hFF, a[7], a[7:1]};     cy = a[0]; end
          default: r = 16'hDEAD;
        endcase
      end else begin
        case (opc)
          5'd8:  begin r = {a[14:0], a[15]};          cy = a[15]; end
          5'd9:  begin r = {a[0], a[15:1]};           cy = a[0];  end
          5'd12: begin r = {a[14:0], 1'b0};           cy = a[15]; end
          5'd13: begin r = {1'b0, a[15:1]};           cy = a[0];  end
          5'd15: begin r = {a[15], a[15:1]};          cy = a[0];  end
          default: r = 16'hDEAD;
        endcase
      end
    end
    msb = sz ? r[15] : r[7];
    z   = sz ? (r == 16'd0) : (r[7:0] == 8'd0);
    return {r, z, msb, ~^r[7:0], msb ^ cy, cy, 1'b0};
  endfunction

  assign {alu_r, alu_flags} = alu_model(alu_op, alu_size, alu_a, alu_b);

  typedef struct packed {
    logic [31:0] t;
    logic [15:0] res;
    logic [5:0]  fl;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.t);
        check("result", {16'd0, result}, {16'd0, e.res});
        check("flags_we", {31'b0, flags_we}, {31'b0, e.we});
        if (e.we) check("flags", {26'd0, flags}, {26'd0, e.fl});
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic run_op(input logic [4:0] o, input logic sz, input logic [15:0] opd,
                        input logic [7:0] cnt, input int n, input logic [15:0] er,
                        input logic [5:0] ef, input logic ewe);
    exp_t e;
    wait_idle();
    op = o; size = sz; operand = opd; count = cnt; start = 1'b1;
    e.t   = cyc + 1 + n;
    e.res = er;
    e.fl  = ef;
    e.we  = ewe;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    exp_t e;
    reset = 1'b1; start = 1'b0; op = 5'd0; size = 1'b0; operand = 16'd0; count = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_busy",     {31'b0, busy},     32'd0);
    check("rst_done",     {31'b0, done},     32'd0);
    check("rst_result",   {16'd0, result},   32'd0);
    check("rst_flags",    {26'd0, flags},    32'd0);
    check("rst_flags_we", {31'b0, flags_we}, 32'd0);
    check("rst_alu_op",   {27'd0, alu_op},   32'd0);
    check("rst_alu_a",    {16'd0, alu_a},    32'd0);
    check("rst_alu_b",    {16'd0, alu_b},    32'd0);
    reset = 1'b0;
    @(negedge clk);

    // op, size, operand, count, effective count, result, flags, flags_we
    run_op(5'd12, 1'b1, 16'h8001, 8'd1,    1,  16'h0002, 6'h06, 1'b1);
    run_op(5'd8,  1'b0, 16'hAB81, 8'd3,    3,  16'hAB0C, 6'h08, 1'b1);
    run_op(5'd12, 1'b0, 16'h12C0, 8'd2,    2,  16'h1200, 6'h2E, 1'b1);
    run_op(5'd13, 1'b1, 16'h8000, 8'h2F,   15, 16'h0001, 6'h00, 1'b1);
    run_op(5'd15, 1'b1, 16'h8001, 8'd4,    4,  16'hF800, 6'h1C, 1'b1);
    run_op(5'd9,  1'b0, 16'h3401, 8'd1,    1,  16'h3480, 6'h12, 1'b1);
    run_op(5'd12, 1'b1, 16'h0001, 8'd31,   31, 16'h0000, 6'h28, 1'b1);
    run_op(5'd12, 1'b1, 16'h1234, 8'd0,    0,  16'h1234, 6'h00, 1'b0);
    run_op(5'd14, 1'b1, 16'h5678, 8'd3,    0,  16'h5678, 6'h00, 1'b0);
    run_op(5'd13, 1'b1, 16'h9ABC, 8'h20,   0,  16'h9ABC, 6'h00, 1'b0);
    run_op(5'd10, 1'b0, 16'h00FF, 8'd1,    0,  16'h00FF, 6'h00, 1'b0);

    // Reset lands on edge E0+3 of a count-10 operation.
    wait_idle();
    op = 5'd12; size = 1'b1; operand = 16'h0001; count = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy",     {31'b0, busy},     32'd0);
    check("midrst_done",     {31'b0, done},     32'd0);
    check("midrst_result",   {16'd0, result},   32'd0);
    check("midrst_flags",    {26'd0, flags},    32'd0);
    check("midrst_flags_we", {31'b0, flags_we}, 32'd0);
    check("midrst_alu_a",    {16'd0, alu_a},    32'd0);
    check("midrst_alu_b",    {16'd0, alu_b},    32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midrst_no_done", seen, 32'd0);

    // A start pulsed while busy must be ignored.
    wait_idle();
    op = 5'd12; size = 1'b1; operand = 16'h0001; count = 8'd5; start = 1'b1;
    e.t = cyc + 1 + 5; e.res = 16'h0020; e.fl = 6'h00; e.we = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = 5'd9; size = 1'b0; operand = 16'hFFFF; count = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_during_run", {31'b0, busy}, 32'd1);
    wait_idle();
    repeat (6) @(negedge clk);
    check("no_extra_busy", {31'b0, busy}, 32'd0);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
